// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, lane helpers.
// Latency: none; this file holds only constants, types and combinational helpers.
// Backpressure: not applicable.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Byte lanes touched by an access of 2**size bytes starting at byte offset off.
    function automatic logic [7:0] byte_enable(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

    // Bring the addressed bytes down to bit 0, then sign- or zero-extend by funct3.
    function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [2:0] f3,
                                                input logic [2:0] off);
        logic [63:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    return {{56{sh[7]}},  sh[7:0]};
            F3_H:    return {{48{sh[15]}}, sh[15:0]};
            F3_W:    return {{32{sh[31]}}, sh[31:0]};
            F3_BU:   return {56'd0, sh[7:0]};
            F3_HU:   return {48'd0, sh[15:0]};
            F3_WU:   return {32'd0, sh[31:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH_WORDS x 64 data RAM with per-byte write enables.
// Latency: writes land on the clock edge; reads appear one cycle after re.
// Backpressure: none; always ready for a read or a write every cycle.
module dmem_ram #(
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic [7:0]       we,
    input  logic [63:0]      wdata,
    input  logic             re,
    output logic [63:0]      rdata
);

    logic [63:0] mem [DEPTH_WORDS];

    // Byte-masked write and registered read of the same word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (we[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_lsu.sv
// RV64I load/store stage: ALU address + rs2 in, extended load data and fault flags out.
// Latency: store/fault response 1 cycle after acceptance, load response 2 cycles after.
// Backpressure: req_ready drops while a request is in flight; the response pulse cannot be stalled.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        rsp_valid,
    output logic [63:0] rdata,
    output logic        err_illegal,
    output logic        err_misaligned,
    output logic        err_range
);

    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_WORDS) << 3;

    lsu_state_t       state;
    logic [2:0]       f3_q;
    logic [2:0]       off_q;

    logic             accept;
    logic [IDX_W-1:0] word_idx;
    logic [2:0]       byte_off;
    logic [1:0]       acc_size;
    logic             is_illegal;
    logic             is_misaligned;
    logic             is_range;
    logic             is_fault;
    logic [7:0]       ram_we;
    logic [63:0]      ram_wdata;
    logic             ram_re;
    logic [63:0]      ram_rdata;

    assign accept   = req_valid && req_ready;
    assign word_idx = addr[IDX_W+2:3];
    assign byte_off = addr[2:0];
    assign acc_size = funct3[1:0];

    // Fault classification; the full 64-bit compare keeps high address bits from aliasing.
    always_comb begin
        is_illegal    = req_write ? funct3[2] : (funct3 == 3'b111);
        is_misaligned = 1'b0;
        case (acc_size)
            2'b01:   is_misaligned = addr[0];
            2'b10:   is_misaligned = |addr[1:0];
            2'b11:   is_misaligned = |addr[2:0];
            default: is_misaligned = 1'b0;
        endcase
        is_range = (addr >= ADDR_LIMIT);
        is_fault = is_illegal || is_misaligned || is_range;
    end

    // RAM is driven straight from the request on the acceptance edge: stores commit there,
    // and loads start the word read there so it is ready to extend while in READ.
    // Gating with rst_n keeps a store presented during reset from writing.
    always_comb begin
        ram_we    = 8'h00;
        ram_re    = 1'b0;
        ram_wdata = wdata << {byte_off, 3'b000};
        if (accept && rst_n && !is_fault) begin
            if (req_write) begin
                ram_we = byte_enable(acc_size, byte_off);
            end else begin
                ram_re = 1'b1;
            end
        end
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk  (clk),
        .addr (word_idx),
        .we   (ram_we),
        .wdata(ram_wdata),
        .re   (ram_re),
        .rdata(ram_rdata)
    );

    // Request FSM with registered handshake, response data and fault flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rdata          <= '0;
            err_illegal    <= 1'b0;
            err_misaligned <= 1'b0;
            err_range      <= 1'b0;
            f3_q           <= '0;
            off_q          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        f3_q      <= funct3;
                        off_q     <= byte_off;
                        req_ready <= 1'b0;
                        if (is_fault || req_write) begin
                            state          <= RESP;
                            rsp_valid      <= 1'b1;
                            err_illegal    <= is_illegal;
                            err_misaligned <= !is_illegal && is_misaligned;
                            err_range      <= !is_illegal && !is_misaligned && is_range;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rdata     <= load_extend(ram_rdata, f3_q, off_q);
                end
                RESP: begin
                    state          <= IDLE;
                    req_ready      <= 1'b1;
                    rsp_valid      <= 1'b0;
                    rdata          <= '0;
                    err_illegal    <= 1'b0;
                    err_misaligned <= 1'b0;
                    err_range      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed vectors plus random traffic against a byte-array model.
// Latency: checks response timing (1 cycle stores/faults, 2 cycles loads) on every request.
// Backpressure: exercises req_valid held high and resets in the middle of a request.
module tb_data_mem_lsu;

    localparam int DEPTH = 128;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] wd;
        logic [63:0] rd;
        logic [2:0]  err;   // {illegal, misaligned, range}
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        rsp_valid;
    logic [63:0] rdata;
    logic        err_illegal;
    logic        err_misaligned;
    logic        err_range;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] mem_m [0:DEPTH*8-1];

    always #5 clk = ~clk;

    data_mem_lsu #(.DEPTH_WORDS(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .funct3        (funct3),
        .addr          (addr),
        .wdata         (wdata),
        .rsp_valid     (rsp_valid),
        .rdata         (rdata),
        .err_illegal   (err_illegal),
        .err_misaligned(err_misaligned),
        .err_range     (err_range)
    );

    // Reference: memory as a flat byte array, accesses computed from size/sign rules.
    function automatic void model(input logic w, input logic [2:0] f3, input logic [63:0] a,
                                  input logic [63:0] wd, output logic [63:0] rd,
                                  output logic [2:0] err, output int lat);
        int          size;
        bit          ill, mis, rng;
        logic [63:0] v;
        size = 1 << f3[1:0];
        ill  = w ? (f3 >= 3'd4) : (f3 == 3'd7);
        mis  = (a % size) != 0;
        rng  = a >= 64'(DEPTH * 8);
        rd   = '0;
        err  = '0;
        lat  = (w || ill || mis || rng) ? 1 : 2;
        if (ill)      err = 3'b100;
        else if (mis) err = 3'b010;
        else if (rng) err = 3'b001;
        else if (w) begin
            for (int i = 0; i < size; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v |= 64'(mem_m[int'(a) + i]) << (8 * i);
            if (!f3[2] && size < 8 && v[8*size-1]) v |= ~((64'd1 << (8 * size)) - 64'd1);
            rd = v;
        end
    endfunction

    // Drive one request, then wait (bounded) for the response pulse and capture it.
    task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, output int lat, output logic [63:0] rd,
                         output logic [2:0] err);
        @(negedge clk);
        req_write = w; funct3 = f3; addr = a; wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rd = '0; err = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i; rd = rdata; err = {err_illegal, err_misaligned, err_range};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp got %b want 0", rsp_valid); end
        vectors++; if (rdata !== 64'd0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", rdata); end
        vectors++;
        if ({err_illegal, err_misaligned, err_range} !== 3'b000) begin
            miscompares++; $display("FAIL reset_err got %b want 000", {err_illegal, err_misaligned, err_range});
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready got %b want 1", req_ready); end
    endtask

    // Zero the RAM through the DUT so every later load has defined contents.
    task automatic init_mem();
        int lat; logic [63:0] rd; logic [2:0] err;
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, 3'd3, 64'(i * 8), 64'd0, lat, rd, err);
            for (int b = 0; b < 8; b++) mem_m[i*8 + b] = 8'h00;
        end
    endtask

    task automatic run_table(input string tag, input vec_t v[$]);
        int lat, mlat; logic [63:0] rd, mrd; logic [2:0] err, merr;
        foreach (v[i]) begin
            issue(v[i].w, v[i].f3, v[i].a, v[i].wd, lat, rd, err);
            model(v[i].w, v[i].f3, v[i].a, v[i].wd, mrd, merr, mlat);
            vectors++;
            if (lat !== v[i].lat) begin miscompares++; $display("FAIL %s[%0d] latency got %0d want %0d", tag, i, lat, v[i].lat); end
            vectors++;
            if (rd !== v[i].rd) begin miscompares++; $display("FAIL %s[%0d] rdata got %h want %h", tag, i, rd, v[i].rd); end
            vectors++;
            if (err !== v[i].err) begin miscompares++; $display("FAIL %s[%0d] err got %b want %b", tag, i, err, v[i].err); end
        end
    endtask

    task automatic test_store_load();
        vec_t v[$];
        v.push_back('{1, 3'd3, 64'h10, 64'h1122334455667788, 64'h0, 3'b000, 1});
        v.push_back('{0, 3'd3, 64'h10, 64'h0, 64'h1122334455667788, 3'b000, 2});
        v.push_back('{1, 3'd0, 64'h13, 64'hFFFFFFFFFFFFFF80, 64'h0, 3'b000, 1});
        v.push_back('{0, 3'd0, 64'h13, 64'h0, 64'hFFFFFFFFFFFFFF80, 3'b000, 2});
        v.push_back('{0, 3'd4, 64'h13, 64'h0, 64'h0000000000000080, 3'b000, 2});
        v.push_back('{0, 3'd3, 64'h10, 64'h0, 64'h1122334480667788, 3'b000, 2});
        v.push_back('{1, 3'd2, 64'h20, 64'hDEADBEEF89ABCDEF, 64'h0, 3'b000, 1});
        v.push_back('{0, 3'd2, 64'h20, 64'h0, 64'hFFFFFFFF89ABCDEF, 3'b000, 2});
        v.push_back('{0, 3'd6, 64'h20, 64'h0, 64'h0000000089ABCDEF, 3'b000, 2});
        v.push_back('{0, 3'd1, 64'h22, 64'h0, 64'hFFFFFFFFFFFF89AB, 3'b000, 2});
        v.push_back('{0, 3'd5, 64'h22, 64'h0, 64'h00000000000089AB, 3'b000, 2});
        v.push_back('{0, 3'd3, 64'h20, 64'h0, 64'h0000000089ABCDEF, 3'b000, 2});
        run_table("store_load", v);
    endtask

    task automatic test_faults();
        vec_t v[$];
        v.push_back('{0, 3'd2, 64'h12, 64'h0, 64'h0, 3'b010, 1});
        v.push_back('{1, 3'd3, 64'h400, 64'hFFFFFFFFFFFFFFFF, 64'h0, 3'b001, 1});
        v.push_back('{0, 3'd3, 64'h0, 64'h0, 64'h0, 3'b000, 2});
        v.push_back('{0, 3'd7, 64'h10, 64'h0, 64'h0, 3'b100, 1});
        v.push_back('{1, 3'd1, 64'h401, 64'h1234, 64'h0, 3'b010, 1});
        v.push_back('{1, 3'd4, 64'h10, 64'hFF, 64'h0, 3'b100, 1});
        v.push_back('{1, 3'd3, 64'h0000000100000010, 64'hFFFFFFFFFFFFFFFF, 64'h0, 3'b001, 1});
        v.push_back('{0, 3'd3, 64'h10, 64'h0, 64'h1122334480667788, 3'b000, 2});
        v.push_back('{0, 3'd0, 64'h3FF, 64'h0, 64'h0, 3'b000, 2});
        v.push_back('{1, 3'd3, 64'h3F8, 64'hA5A5A5A5A5A5A5A5, 64'h0, 3'b000, 1});
        v.push_back('{0, 3'd6, 64'h3FC, 64'h0, 64'h00000000A5A5A5A5, 3'b000, 2});
        v.push_back('{0, 3'd0, 64'h3F8, 64'h0, 64'hFFFFFFFFFFFFFFA5, 3'b000, 2});
        run_table("faults", v);
    endtask

    task automatic test_back_to_back();
        logic [63:0] mrd; logic [2:0] merr; int mlat;
        int pulses = 0;
        bit exp_rdy, exp_rsp;
        model(1'b0, 3'd3, 64'h10, 64'd0, mrd, merr, mlat);
        @(negedge clk);
        req_write = 1'b0; funct3 = 3'd3; addr = 64'h10; req_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 7) req_valid = 1'b0;
            exp_rdy = (k >= 9) || (k % 3 == 0);
            exp_rsp = (k < 9) && (k % 3 == 2);
            vectors++;
            if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL b2b_ready cycle %0d got %b want %b", k, req_ready, exp_rdy); end
            vectors++;
            if (rsp_valid !== exp_rsp) begin miscompares++; $display("FAIL b2b_rsp cycle %0d got %b want %b", k, rsp_valid, exp_rsp); end
            if (rsp_valid === 1'b1) begin
                pulses++;
                vectors++;
                if (rdata !== mrd) begin miscompares++; $display("FAIL b2b_rdata cycle %0d got %h want %h", k, rdata, mrd); end
            end
        end
        vectors++;
        if (pulses != 3) begin miscompares++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        req_write = 1'b0; funct3 = 3'd3; addr = 64'h18; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rst_n = 1'b1;
            vectors++;
            if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_rsp cycle %0d got %b want 0", k, rsp_valid); end
        end
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready got %b want 1", req_ready); end
    endtask

    task automatic test_reset_store();
        int lat, mlat; logic [63:0] rd, mrd; logic [2:0] err, merr;
        @(negedge clk);
        rst_n = 1'b0;
        req_write = 1'b1; funct3 = 3'd3; addr = 64'h10; wdata = 64'hDEADDEADDEADDEAD; req_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; req_valid = 1'b0;
        issue(1'b0, 3'd3, 64'h10, 64'd0, lat, rd, err);
        model(1'b0, 3'd3, 64'h10, 64'd0, mrd, merr, mlat);
        vectors++;
        if (rd !== mrd) begin miscompares++; $display("FAIL rst_store_rdata got %h want %h", rd, mrd); end
        vectors++;
        if (lat !== mlat) begin miscompares++; $display("FAIL rst_store_latency got %0d want %0d", lat, mlat); end
    endtask

    task automatic test_random();
        int lat, mlat; logic [63:0] rd, mrd, a, wd; logic [2:0] err, merr, f3; logic w;
        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wd = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                7:       a = 64'($urandom_range(0, DEPTH - 1)) << 3;
                8:       a = 64'(DEPTH * 8 + $urandom_range(0, 255));
                9:       a = {1'b1, 31'($urandom), 32'($urandom_range(0, 255))};
                default: a = 64'($urandom_range(0, 127));
            endcase
            issue(w, f3, a, wd, lat, rd, err);
            model(w, f3, a, wd, mrd, merr, mlat);
            vectors++;
            if (lat !== mlat) begin miscompares++; $display("FAIL rand[%0d] latency got %0d want %0d", n, lat, mlat); end
            vectors++;
            if (rd !== mrd) begin miscompares++; $display("FAIL rand[%0d] rdata got %h want %h (w=%b f3=%0d a=%h)", n, rd, mrd, w, f3, a); end
            vectors++;
            if (err !== merr) begin miscompares++; $display("FAIL rand[%0d] err got %b want %b (w=%b f3=%0d a=%h)", n, err, merr, w, f3, a); end
        end
    endtask

    initial begin
        test_reset();
        init_mem();
        test_store_load();
        test_faults();
        test_back_to_back();
        test_reset_mid_load();
        test_reset_store();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d vectors", vectors);
        $fatal(1, "watchdog");
    end

endmodule
